// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// default sequential PC increment, reset PC and the word-alignment width.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fetch_state_e;

  localparam int          DEF_PC_STEP = 4;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  // Number of low address bits forced to zero to word-align a PC.
  localparam int          ALIGN_BITS  = 2;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read port: req/ready handshake with address and data.
// master = fetch unit, slave = instruction memory.
interface instr_fetch_unit_if #(
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/instr_fetch_unit_timeout_ctr.sv
// FETCH watchdog: counts cycles while enabled and flags the last allowed
// cycle. Only compiled when FETCH_TIMEOUT_EN is defined.
`ifdef FETCH_TIMEOUT_EN
module fetch_timeout_ctr #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // expired is high during the LIMIT-th enabled cycle since the last clear
  assign expired = en && (cnt_q == CW'(LIMIT - 1));

  // next count: clear wins, otherwise advance until expiry
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule
`endif

// File: rtl/instr_fetch_unit.sv
// Multi-cycle MIPS instruction fetch engine: IDLE -> FETCH -> DONE -> IDLE.
// Reads the PC, fetches one word over the req/ready port, latches the IR and
// returns the next PC (sequential or redirect) with a one-cycle write strobe.
// Optional FETCH timeout is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int PC_STEP        = DEF_PC_STEP,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_start,
  input  logic [DATA_W-1:0]      pc_cur,
  input  logic                   redirect_valid,
  input  logic [DATA_W-1:0]      redirect_target,
  output logic [DATA_W-1:0]      pc_next,
  output logic                   pc_write,
  instr_fetch_unit_if.master     mem,
  output logic [DATA_W-1:0]      ir_out,
  output logic                   ir_valid,
  output logic                   busy,
  output logic                   fetch_err
);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] pc_next_q, pc_next_d;
  logic              pc_write_q, pc_write_d;
  logic              mem_req_q, mem_req_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              busy_q, busy_d;
  logic              fetch_err_q, fetch_err_d;
  logic              timeout_hit;
  logic [DATA_W-1:0] pc_cur_al, redirect_al;

  assign pc_cur_al   = {pc_cur[DATA_W-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
  assign redirect_al = {redirect_target[DATA_W-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};

`ifdef FETCH_TIMEOUT_EN
  // counter is held clear while idle, so every FETCH starts from zero
  fetch_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == IDLE),
    .en      (state_q == FETCH),
    .expired (timeout_hit)
  );
`else
  // no watchdog in this build: FETCH waits for mem_ready indefinitely
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  // next-state and registered-output logic; redirect has top priority
  always_comb begin
    state_d     = state_q;
    pc_next_d   = pc_next_q;
    pc_write_d  = 1'b0;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    ir_d        = ir_q;
    ir_valid_d  = 1'b0;
    busy_d      = busy_q;
    fetch_err_d = 1'b0;

    if (redirect_valid) begin
      pc_next_d  = redirect_al;
      pc_write_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (!redirect_valid && fetch_start) begin
          state_d    = FETCH;
          mem_addr_d = pc_cur_al;
          mem_req_d  = 1'b1;
          busy_d     = 1'b1;
        end
      end
      FETCH: begin
        if (redirect_valid) begin
          // abort: any data arriving this cycle is dropped
          state_d   = IDLE;
          mem_req_d = 1'b0;
          busy_d    = 1'b0;
        end else if (timeout_hit) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          busy_d      = 1'b0;
          fetch_err_d = 1'b1;
        end else if (mem.mem_ready) begin
          state_d    = DONE;
          ir_d       = mem.mem_rdata;
          ir_valid_d = 1'b1;
          pc_next_d  = mem_addr_q + DATA_W'(PC_STEP);
          pc_write_d = 1'b1;
          mem_req_d  = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_next_q   <= DATA_W'(RESET_PC);
      pc_write_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_next_q   <= pc_next_d;
      pc_write_q  <= pc_write_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      ir_q        <= ir_d;
      ir_valid_q  <= ir_valid_d;
      busy_q      <= busy_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign pc_next      = pc_next_q;
  assign pc_write     = pc_write_q;
  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign ir_out       = ir_q;
  assign ir_valid     = ir_valid_q;
  assign busy         = busy_q;
  assign fetch_err    = fetch_err_q;

endmodule
